// File: rtl/svga_timing_pkg.sv
// svga_timing_pkg: 800x600@72 Hz scan timing, slice geometry and scan state encoding.
package svga_timing_pkg;
    localparam int H_ACTIVE    = 800;
    localparam int H_FP        = 56;
    localparam int H_SYNC      = 120;
    localparam int H_BP        = 64;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int V_ACTIVE    = 600;
    localparam int V_FP        = 37;
    localparam int V_SYNC      = 6;
    localparam int V_BP        = 23;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC;
    localparam int SLICE_LINES = 150;
    localparam int SLICE_WORDS = SLICE_LINES * H_ACTIVE;
    localparam int RD_LAT      = 1;
    localparam logic SYNC_POL  = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;
endpackage

// File: rtl/frame_scan_sequencer_delay.sv
// sync_delay_line: DEPTH-stage register delay with an asynchronous reset to a supplied value.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q << WIDTH;
        pipe_d[0] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= {DEPTH{rst_val}};
        else        pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/frame_scan_sequencer.sv
// frame_scan_sequencer: scan counters, sync/blanking strobes and slice read addressing,
// with hsync/vsync/de delayed to line up with the colour lookup's registered data.
module frame_scan_sequencer #(
    parameter int   H_ACTIVE    = svga_timing_pkg::H_ACTIVE,
    parameter int   H_FP        = svga_timing_pkg::H_FP,
    parameter int   H_SYNC      = svga_timing_pkg::H_SYNC,
    parameter int   H_BP        = svga_timing_pkg::H_BP,
    parameter int   V_ACTIVE    = svga_timing_pkg::V_ACTIVE,
    parameter int   V_FP        = svga_timing_pkg::V_FP,
    parameter int   V_SYNC      = svga_timing_pkg::V_SYNC,
    parameter int   V_BP        = svga_timing_pkg::V_BP,
    parameter int   SLICE_LINES = svga_timing_pkg::SLICE_LINES,
    parameter int   RD_LAT      = svga_timing_pkg::RD_LAT,
    parameter logic SYNC_POL    = svga_timing_pkg::SYNC_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        rd_en,
    output logic [1:0]  slice_sel,
    output logic [16:0] slice_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);
    import svga_timing_pkg::scan_state_t;
    import svga_timing_pkg::IDLE;
    import svga_timing_pkg::RUN;
    import svga_timing_pkg::DRAIN;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  SL1    = 10'(SLICE_LINES);
    localparam logic [9:0]  SL2    = 10'(2 * SLICE_LINES);
    localparam logic [9:0]  SL3    = 10'(3 * SLICE_LINES);

    scan_state_t state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [1:0]  slice_sel_q, slice_sel_d;
    logic [16:0] slice_addr_q, slice_addr_d;
    logic        rd_en_q, rd_en_d, frame_start_q, frame_start_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        last_px, line_end, scan, slice_start;

    always_comb begin
        line_end      = hcount_q == H_LAST;
        last_px       = line_end && vcount_q == V_LAST;
        // Leaving IDLE and finishing a frame both decide purely on en; mid-frame only RUN listens.
        state_d       = (state_q == IDLE || last_px) ? (en ? RUN : IDLE)
                      : (en && state_q == RUN) ? RUN : DRAIN;
        hcount_d      = (state_q == IDLE || line_end) ? '0 : hcount_q + 11'd1;
        vcount_d      = (state_q == IDLE || last_px) ? '0 : line_end ? vcount_q + 10'd1 : vcount_q;
        scan          = state_d != IDLE;
        rd_en_d       = scan && hcount_d < H_ACT && vcount_d < V_ACT;
        slice_start   = hcount_d == '0 && (vcount_d == '0 || vcount_d == SL1 || vcount_d == SL2 || vcount_d == SL3);
        slice_sel_d   = !scan ? 2'd0 : !rd_en_d ? slice_sel_q
                      : vcount_d >= SL3 ? 2'd3 : vcount_d >= SL2 ? 2'd2 : vcount_d >= SL1 ? 2'd1 : 2'd0;
        slice_addr_d  = !scan ? '0 : !rd_en_d ? slice_addr_q : slice_start ? '0 : slice_addr_q + 17'd1;
        frame_start_d = state_d == RUN && hcount_d == '0 && vcount_d == '0;
        hs_d          = scan && hcount_d >= HS_BEG && hcount_d < HS_END ? SYNC_POL : ~SYNC_POL;
        vs_d          = scan && vcount_d >= VS_BEG && vcount_d < VS_END ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            slice_sel_q   <= '0;
            slice_addr_q  <= '0;
            rd_en_q       <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            slice_sel_q   <= slice_sel_d;
            slice_addr_q  <= slice_addr_d;
            rd_en_q       <= rd_en_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    sync_delay_line #(.WIDTH(3), .DEPTH(RD_LAT)) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .rst_val({~SYNC_POL, ~SYNC_POL, 1'b0}),
        .din    ({hs_q, vs_q, rd_en_q}),
        .dout   ({hsync, vsync, de})
    );

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign rd_en       = rd_en_q;
    assign slice_sel   = slice_sel_q;
    assign slice_addr  = slice_addr_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_frame_scan_sequencer.sv
// tb_frame_scan_sequencer: scoreboard bench on a shrunken raster; a position-based
// frame model predicts every output each clock, directed phases cover the scan rules.
module tb_frame_scan_sequencer;
    localparam int HA = 16, HF = 3, HS = 4, HB = 3;
    localparam int VA = 8, VF = 2, VS = 2, VB = 2;
    localparam int SL = 2, RL = 2;
    localparam logic POL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        rd_en, hsync, vsync, de, frame_start;
    logic [1:0]  slice_sel;
    logic [16:0] slice_addr;

    frame_scan_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SLICE_LINES(SL), .RD_LAT(RL), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hcount(hcount), .vcount(vcount), .rd_en(rd_en),
        .slice_sel(slice_sel), .slice_addr(slice_addr),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    typedef struct { int h, v, rd, sel, addr, fs, hs, vs, de; } exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a running flag plus linear position p within the frame.
    bit   m_run;
    int   m_p, m_h, m_v;
    bit   m_act;
    int   hist_h[$], hist_v[$], hist_d[$];
    exp_t m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_p = 0; q.delete();
            hist_h.delete(); hist_v.delete(); hist_d.delete();
            for (int i = 0; i < RL; i++) begin hist_h.push_back(0); hist_v.push_back(0); hist_d.push_back(0); end
        end else begin
            if (!m_run) begin
                if (en) begin m_run = 1; m_p = 0; end
            end else if (m_p == FT - 1) begin
                m_run = en; m_p = 0;
            end else m_p++;
            m_h = m_run ? m_p % HT : 0;
            m_v = m_run ? m_p / HT : 0;
            m_act = m_run && m_h < HA && m_v < VA;
            m_e.h   = m_h;
            m_e.v   = m_v;
            m_e.rd  = m_act;
            m_e.fs  = m_run && m_p == 0;
            m_e.sel = m_run ? ((m_v < VA ? m_v : VA - 1) / SL) : 0;
            m_e.addr = !m_run ? 0 : m_act ? (m_v % SL) * HA + m_h
                     : m_v < VA ? (m_v % SL) * HA + HA - 1 : SL * HA - 1;
            hist_h.push_back(m_run && m_h >= HA + HF && m_h < HA + HF + HS);
            hist_v.push_back(m_run && m_v >= VA + VF && m_v < VA + VF + VS);
            hist_d.push_back(m_act);
            m_e.hs = hist_h.pop_front() ? POL : !POL;
            m_e.vs = hist_v.pop_front() ? POL : !POL;
            m_e.de = hist_d.pop_front();
            q.push_back(m_e);
        end
    end

    exp_t c_e;
    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            c_e = q.pop_front();
            chk("hcount", hcount, c_e.h);
            chk("vcount", vcount, c_e.v);
            chk("rd_en", rd_en, c_e.rd);
            chk("slice_sel", slice_sel, c_e.sel);
            chk("slice_addr", slice_addr, c_e.addr);
            chk("frame_start", frame_start, c_e.fs);
            chk("hsync", hsync, c_e.hs);
            chk("vsync", vsync, c_e.vs);
            chk("de", de, c_e.de);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hcount"}, hcount, 0);
        chk({tag, "_vcount"}, vcount, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_slice_sel"}, slice_sel, 0);
        chk({tag, "_slice_addr"}, slice_addr, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_hsync"}, hsync, !POL);
        chk({tag, "_vsync"}, vsync, !POL);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(hcount == h && vcount == v) && n < 2 * FT) begin @(negedge clk); n++; end
        chk("wait_pos_reached", int'(hcount == h && vcount == v), 1);
    endtask

    int n, rd_cnt, vs_cnt;

    initial begin
        #1 rst_n = 1'b0;
        #3 chk_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("first_frame_start", frame_start, 1);
        chk("first_pos", hcount + vcount, 0);
        n = 0; rd_cnt = rd_en; vs_cnt = (vsync == POL);
        do begin
            @(negedge clk); n++;
            rd_cnt += rd_en; vs_cnt += (vsync == POL);
        end while (!frame_start && n < FT + 10);
        chk("frame_period", n, FT);
        chk("rd_en_per_frame", rd_cnt - rd_en, HA * VA);
        chk("vsync_clocks", vs_cnt, VS * HT);

        wait_pos(0, 4);
        en = 1'b0;
        n = 0;
        while (!(hcount == 0 && vcount == 0 && !rd_en) && n < 2 * FT) begin @(negedge clk); n++; end
        chk("drain_clocks", n, FT - 4 * HT);
        repeat (4) @(negedge clk);
        chk("idle_hold_hcount", hcount, 0);

        en = 1'b1;
        wait_pos(0, 2);
        en = 1'b0;
        wait_pos(HT - 1, VT - 1);
        en = 1'b1;
        @(negedge clk);
        chk("back_to_back_fs", frame_start, 1);

        wait_pos(10, 5);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_fs", frame_start, 1);

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (hcount == HT - 1 && vcount == VT - 1) en = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 299) == 0) en = ~en;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_scan_sequencer.md
# frame_scan_sequencer

Scan controller for the 800x600@72 Hz pixel pipeline. Generates the horizontal and vertical scan counters, the sync and blanking strobes, and the image-slice read addresses (four 800x150 slices stacked vertically) for the colour lookup stage. Sync and display-enable are delayed to line up with the lookup's registered read data. Sits between the 50 MHz pixel clock domain root and the colour lookup / DAC output stage.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync width (clocks)
- H_BP, 64, horizontal back porch; H_TOTAL = 1040
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch; V_TOTAL = 666
- SLICE_LINES, 150, lines per image slice; V_ACTIVE/SLICE_LINES = 4
- RD_LAT, 1, colour lookup read latency in clocks (1..4)
- SYNC_POL, 1, asserted level of hsync/vsync
- clk  in  1  pixel clock, 50 MHz
- rst_n  in  1  reset; asynchronous and active-low
- en  in  1  scan enable request
- hcount  out  11  current column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- rd_en  out  1  slice read strobe (active pixel, undelayed)
- slice_sel  out  2  slice index, vcount/SLICE_LINES
- slice_addr  out  17  linear address in slice, row*800+col
- hsync  out  1  delayed by RD_LAT
- vsync  out  1  delayed by RD_LAT
- de  out  1  display enable, delayed by RD_LAT
- frame_start  out  1  one-clock pulse at hcount=0, vcount=0 while RUN

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: counters held at 0. rd_en, de and frame_start are 0; syncs are at the inactive level. When en=1, the block goes to RUN on the next clock, counting starts at (0,0), and frame_start pulses.
- RUN: hcount increments every clock and wraps at H_TOTAL-1. On the wrap, vcount increments, wrapping at V_TOTAL-1. If en=0 at any point, the state goes to DRAIN.
- DRAIN: the current frame completes normally. At the last pixel of the frame (H_TOTAL-1, V_TOTAL-1):
  - en=1 → return to RUN with no gap.
  - en=0 → IDLE.
  - en is ignored elsewhere in DRAIN.
- Active region: hcount < H_ACTIVE and vcount < V_ACTIVE. rd_en equals the active-region flag.
- Slice mapping:
  - slice_sel = vcount/SLICE_LINES, with no gap lines.
  - Line 150 is slice 1, row 0. Line 149 is slice 0, row 149.
  - Outside the active region, slice_sel holds the last value.
- slice_addr:
  - Incremental counter, +1 per rd_en clock.
  - Cleared to 0 on the first active pixel of lines 0, 150, 300 and 450.
  - Range 0..119999 and never exceeds it. Holds its value during blanking.
- hsync is asserted for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (856..975).
- vsync is asserted for V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (637..642).
- Reset values: state=IDLE, and hcount, vcount, slice_sel, slice_addr, rd_en, de and frame_start all 0. hsync=vsync=~SYNC_POL. The delay line is flushed to the inactive values.
- rst_n asserted mid-frame: all outputs take their reset values immediately, without waiting for a clock edge. After release, the block behaves as from IDLE.

## Timing
- hcount, vcount, rd_en, slice_sel, slice_addr and frame_start are all registered and mutually consistent in the same cycle.
- hsync, vsync and de are the undelayed strobes passed through an RD_LAT-stage register delay. de(t) = rd_en(t−RD_LAT), which aligns de with the lookup's RGB data.
- Line period is 1040 clocks; frame period is 692,640 clocks.
- First frame_start: 1 clock after en is sampled high in IDLE.

## Structure
- Shared package svga_timing_pkg holds:
  - the H_*/V_* timing constants and derived totals and sync bounds;
  - SLICE_LINES and SLICE_WORDS=120000;
  - the scan_state_t enum {IDLE, RUN, DRAIN}.
- Sub-module sync_delay_line has parameters WIDTH and DEPTH and an asynchronous active-low reset value input. It is instantiated once for {hsync, vsync, de}.

## Test plan
- Reset, then en=1 → frame_start pulses 1 clock later with hcount=0, vcount=0. At RD_LAT=1, de first goes high the cycle after rd_en.
- One line at vcount=0 → rd_en high for exactly 800 clocks. hsync asserted at hcount 856..975 (120 clocks). slice_addr reaches 799.
- Slice boundary: at vcount=149, hcount=799, expect slice_sel=0 and slice_addr=119999. At vcount=150, hcount=0, expect slice_sel=1 and slice_addr=0.
- Full frame → 666 lines. vsync asserted on lines 637..642. rd_en counts 480,000 clocks. Next frame_start arrives exactly 692,640 clocks after the previous one.
- Drop en at vcount=300 → frame completes through vcount=665, hcount=1039, then IDLE with counters at 0. Raise en at the last pixel instead → back-to-back frames with no gap.
- rst_n low at vcount=400, hcount=500 → all outputs return to reset values asynchronously. With en=1 held, frame_start recurs 1 clock after reset release.
